// File: rtl/uart_cmd_parser.sv
// Line-oriented ASCII command parser for a UART receiver: collects characters up to LF,
// then decodes LED on/off/all and STATUS commands into registered outputs and pulses.
module uart_cmd_parser #(
  parameter int unsigned MAX_LEN = 8
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic [7:0] o_LEDs,
  output logic       o_Status_Req,
  output logic       o_Cmd_Err,
  output logic       o_Busy
);

  // At least 3 index bits so the fixed-position decode (up to 6 chars) stays in range.
  localparam int unsigned LEN_W = ($clog2(MAX_LEN + 1) < 3) ? 3 : $clog2(MAX_LEN + 1);
  localparam int unsigned BUF_DEPTH = 2 ** LEN_W;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;

  typedef enum logic [1:0] {S_COLLECT, S_DISCARD, S_EXEC} state_e;

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [7:0]       buffer_q [BUF_DEPTH];
  logic [7:0]       leds_q;
  logic             status_q;
  logic             err_q;
  logic             busy_q;

  logic             store;
  logic [7:0]       dec_leds;
  logic             dec_status;
  logic             dec_err;
  logic             digit_ok;
  logic [2:0]       led_idx;

  assign store = (state_q == S_COLLECT) && i_Rx_DV && (i_Rx_Byte != LF) &&
                 (i_Rx_Byte != CR) && (len_q != LEN_W'(MAX_LEN));

  always_ff @(posedge i_Clock) begin
    if (store) begin
      buffer_q[len_q] <= i_Rx_Byte;
    end
  end

  // '1'..'8' map to 1..0 in their low three bits, so subtracting one yields the LED index.
  assign digit_ok = (buffer_q[2] >= 8'h31) && (buffer_q[2] <= 8'h38);
  assign led_idx  = buffer_q[2][2:0] - 3'd1;

  always_comb begin
    dec_leds   = leds_q;
    dec_status = 1'b0;
    dec_err    = 1'b1;
    if (len_q == LEN_W'(3) && buffer_q[0] == 8'h4F && digit_ok) begin
      if (buffer_q[1] == 8'h4E) begin
        dec_leds[led_idx] = 1'b1;
        dec_err           = 1'b0;
      end else if (buffer_q[1] == 8'h46) begin
        dec_leds[led_idx] = 1'b0;
        dec_err           = 1'b0;
      end
    end else if (len_q == LEN_W'(5) && buffer_q[0] == 8'h41 && buffer_q[1] == 8'h4C &&
                 buffer_q[2] == 8'h4C && buffer_q[3] == 8'h4F) begin
      if (buffer_q[4] == 8'h4E) begin
        dec_leds = 8'hFF;
        dec_err  = 1'b0;
      end else if (buffer_q[4] == 8'h46) begin
        dec_leds = 8'h00;
        dec_err  = 1'b0;
      end
    end else if (len_q == LEN_W'(6) && buffer_q[0] == 8'h53 && buffer_q[1] == 8'h54 &&
                 buffer_q[2] == 8'h41 && buffer_q[3] == 8'h54 && buffer_q[4] == 8'h55 &&
                 buffer_q[5] == 8'h53) begin
      dec_status = 1'b1;
      dec_err    = 1'b0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= S_COLLECT;
      len_q    <= '0;
      leds_q   <= 8'h00;
      status_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      status_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        S_COLLECT: begin
          if (i_Rx_DV && i_Rx_Byte != CR) begin
            if (i_Rx_Byte == LF) begin
              if (len_q != '0) begin
                state_q <= S_EXEC;
                busy_q  <= 1'b1;
              end
            end else if (len_q == LEN_W'(MAX_LEN)) begin
              state_q <= S_DISCARD;
            end else begin
              len_q <= len_q + LEN_W'(1);
            end
          end
        end
        S_DISCARD: begin
          if (i_Rx_DV && i_Rx_Byte == LF) begin
            err_q   <= 1'b1;
            len_q   <= '0;
            state_q <= S_COLLECT;
          end
        end
        S_EXEC: begin
          // Any strobe arriving here is intentionally ignored.
          leds_q   <= dec_leds;
          status_q <= dec_status;
          err_q    <= dec_err;
          len_q    <= '0;
          busy_q   <= 1'b0;
          state_q  <= S_COLLECT;
        end
        default: state_q <= S_COLLECT;
      endcase
    end
  end

  assign o_LEDs       = leds_q;
  assign o_Status_Req = status_q;
  assign o_Cmd_Err    = err_q;
  assign o_Busy       = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed scenarios plus random command lines
// compared against a string-level model of the command set.
module tb_uart_cmd_parser;

  localparam int MAX_LEN = 8;

  logic       clk;
  logic       rst_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic [7:0] leds;
  logic       status_req;
  logic       cmd_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_leds = 8'h00;

  uart_cmd_parser #(.MAX_LEN(MAX_LEN)) dut (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_Rx_DV     (rx_dv),
    .i_Rx_Byte   (rx_byte),
    .o_LEDs      (leds),
    .o_Status_Req(status_req),
    .o_Cmd_Err   (cmd_err),
    .o_Busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (status_req && cmd_err) begin
      errors++;
      $display("FAIL pulse_exclusive: status_req=%0b cmd_err=%0b required not both high",
               status_req, cmd_err);
    end
  end

  // Model: what a complete (CR-stripped) line does to the LEDs and pulses.
  function automatic void model_line(input string s, input logic [7:0] l_in,
                                     output logic [7:0] l_out, output bit st, output bit er);
    byte c;
    l_out = l_in;
    st    = 1'b0;
    er    = 1'b1;
    if (s == "ALLON") begin
      l_out = 8'hFF; er = 1'b0;
    end else if (s == "ALLOF") begin
      l_out = 8'h00; er = 1'b0;
    end else if (s == "STATUS") begin
      st = 1'b1; er = 1'b0;
    end else if (s.len() == 3) begin
      c = s[2];
      if (c >= 8'h31 && c <= 8'h38) begin
        if (s.substr(0, 1) == "ON") begin
          l_out[int'(c) - 49] = 1'b1; er = 1'b0;
        end else if (s.substr(0, 1) == "OF") begin
          l_out[int'(c) - 49] = 1'b0; er = 1'b0;
        end
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Sends one line (optionally sprinkled with CRs) and checks the response timing.
  task automatic run_line(input string s, input bit add_cr, input bit drop_in_exec);
    logic [7:0] new_leds;
    bit st, er;
    model_line(s, exp_leds, new_leds, st, er);
    for (int i = 0; i < s.len(); i++) begin
      if (add_cr && $urandom_range(0, 3) == 0) send_byte(8'h0D);
      send_byte(s[i]);
    end
    if (add_cr) send_byte(8'h0D);
    send_byte(8'h0A);
    @(negedge clk);
    rx_dv = 1'b0;
    if (s.len() == 0) begin
      for (int k = 0; k < 3; k++) begin
        chk("empty_err", {7'd0, cmd_err}, 8'd0);
        chk("empty_status", {7'd0, status_req}, 8'd0);
        chk("empty_busy", {7'd0, busy}, 8'd0);
        chk("empty_leds", leds, exp_leds);
        @(negedge clk);
      end
    end else if (s.len() > MAX_LEN) begin
      chk("overlong_err", {7'd0, cmd_err}, 8'd1);
      chk("overlong_busy", {7'd0, busy}, 8'd0);
      chk("overlong_leds", leds, exp_leds);
      @(negedge clk);
      chk("overlong_err_end", {7'd0, cmd_err}, 8'd0);
    end else begin
      chk("exec_busy", {7'd0, busy}, 8'd1);
      chk("exec_early_err", {7'd0, cmd_err}, 8'd0);
      chk("exec_early_status", {7'd0, status_req}, 8'd0);
      chk("exec_early_leds", leds, exp_leds);
      if (drop_in_exec) begin
        rx_dv   = 1'b1;
        rx_byte = 8'h5A;
      end
      @(negedge clk);
      rx_dv = 1'b0;
      chk("exec_leds", leds, new_leds);
      chk("exec_status", {7'd0, status_req}, {7'd0, st});
      chk("exec_err", {7'd0, cmd_err}, {7'd0, er});
      chk("exec_busy_end", {7'd0, busy}, 8'd0);
      exp_leds = new_leds;
      @(negedge clk);
      chk("pulse_end_status", {7'd0, status_req}, 8'd0);
      chk("pulse_end_err", {7'd0, cmd_err}, 8'd0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_leds", leds, 8'h00);
    chk("reset_status", {7'd0, status_req}, 8'd0);
    chk("reset_err", {7'd0, cmd_err}, 8'd0);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    rst_n = 1'b1;
    exp_leds = 8'h00;
  endtask

  task automatic test_on1();
    run_line("ON1", 1'b0, 1'b0);
    chk("on1_leds", leds, 8'h01);
  endtask

  task automatic test_sequence();
    run_line("ON2", 1'b0, 1'b0);
    chk("seq_on2", leds, 8'h03);
    run_line("OF1", 1'b0, 1'b0);
    chk("seq_of1", leds, 8'h02);
    run_line("OF1", 1'b0, 1'b0);
    chk("seq_of1_again", leds, 8'h02);
  endtask

  task automatic test_status();
    run_line("STATUS", 1'b1, 1'b0);
    chk("status_leds", leds, 8'h02);
  endtask

  task automatic test_errors();
    run_line("ON9", 1'b0, 1'b0);
    run_line("ABCDEFGHIJ", 1'b0, 1'b0);
    run_line("", 1'b0, 1'b0);
    run_line("ABCDEFGH", 1'b0, 1'b0);
    run_line("ABCDEFGHI", 1'b0, 1'b0);
    run_line("on1", 1'b0, 1'b0);
    chk("errors_leds", leds, 8'h02);
  endtask

  task automatic test_all();
    run_line("ALLON", 1'b0, 1'b0);
    chk("allon", leds, 8'hFF);
    run_line("ALLOF", 1'b0, 1'b0);
    chk("allof", leds, 8'h00);
  endtask

  task automatic test_exec_drop();
    run_line("ON4", 1'b0, 1'b1);
    run_line("ON5", 1'b0, 1'b0);
    chk("exec_drop_leds", leds, 8'h18);
  endtask

  task automatic test_reset_midcmd();
    run_line("ALLON", 1'b0, 1'b0);
    send_byte("O");
    send_byte("N");
    @(negedge clk);
    rx_dv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_leds", leds, 8'h00);
    chk("async_reset_busy", {7'd0, busy}, 8'd0);
    exp_leds = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    run_line("3", 1'b0, 1'b0);
    chk("reset_mid_leds", leds, 8'h00);
    run_line("", 1'b0, 1'b0);
  endtask

  function automatic string gen_line();
    string s;
    s = "";
    case ($urandom_range(0, 9))
      0, 1: s = $sformatf("ON%0d", $urandom_range(0, 9));
      2, 3: s = $sformatf("OF%0d", $urandom_range(0, 9));
      4: s = "ALLON";
      5: s = "ALLOF";
      6: s = "STATUS";
      7: begin
        case ($urandom_range(0, 4))
          0: s = "on1";
          1: s = "ON12";
          2: s = "STATU";
          3: s = "STATUSX";
          default: s = "OF";
        endcase
      end
      default: begin
        int n;
        n = $urandom_range(0, 11);
        for (int i = 0; i < n; i++) s = $sformatf("%s%c", s, 8'($urandom_range(65, 90)));
      end
    endcase
    return s;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      run_line(gen_line(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk("random_final_leds", leds, exp_leds);
  endtask

  initial begin
    test_reset();
    test_on1();
    test_sequence();
    test_status();
    test_errors();
    test_all();
    test_exec_drop();
    test_reset_midcmd();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 8, giving the command buffer depth in characters, excluding the terminator.
REQ-002 The block SHALL have port i_Clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_Rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port i_Rx_DV, input, 1 bit: single-cycle strobe from the UART receiver meaning i_Rx_Byte is valid.
REQ-005 The block SHALL have port i_Rx_Byte, input, 8 bits: received ASCII character.
REQ-006 The block SHALL have port o_LEDs, output, 8 bits: registered LED state; bit k drives LED k+1.
REQ-007 The block SHALL have port o_Status_Req, output, 1 bit: one-cycle pulse requesting a sensor status report from the downstream TX formatter.
REQ-008 The block SHALL have port o_Cmd_Err, output, 1 bit: one-cycle pulse flagging an unrecognised or overlong command.
REQ-009 The block SHALL have port o_Busy, output, 1 bit: high while in S_EXEC.

Function
REQ-010 The block SHALL implement states S_COLLECT, S_DISCARD and S_EXEC, with S_COLLECT as the reset state.
REQ-011 In S_COLLECT, a byte other than 0x0A or 0x0D SHALL be stored at buffer[len], and len SHALL increment.
REQ-012 Byte 0x0D SHALL be ignored in every state: it is not stored and causes no state change.
REQ-013 In S_COLLECT, a storable byte arriving when len == MAX_LEN SHALL move the block to S_DISCARD without storing the byte.
REQ-014 In S_DISCARD, all bytes except 0x0A SHALL be dropped; 0x0A SHALL pulse o_Cmd_Err on the next cycle, clear len and return to S_COLLECT.
REQ-015 In S_COLLECT, 0x0A with len == 0 SHALL clear len and cause no output action and no error.
REQ-016 In S_COLLECT, 0x0A with len > 0 SHALL move the block to S_EXEC on the next edge.
REQ-017 S_EXEC SHALL last exactly one cycle; it SHALL decode the buffer, update outputs at the edge leaving S_EXEC, clear len and return to S_COLLECT.
REQ-018 Latency: o_LEDs change and the o_Status_Req / o_Cmd_Err pulse SHALL be visible 2 cycles after the cycle in which i_Rx_DV carried the 0x0A.
REQ-019 Decoding SHALL be an exact, case-sensitive match on both length and content.
REQ-020 "ONd" with d in '1'..'8' SHALL set o_LEDs[d-'1']; all other bits are unchanged.
REQ-021 "OFd" with d in '1'..'8' SHALL clear o_LEDs[d-'1']; all other bits are unchanged.
REQ-022 "ALLON" SHALL set o_LEDs to 8'hFF, and "ALLOF" SHALL set o_LEDs to 8'h00.
REQ-023 "STATUS" SHALL pulse o_Status_Req for one cycle and leave o_LEDs unchanged.
REQ-024 Any other non-empty line, including "ON0", "ON9", "on1" and "ON12", SHALL pulse o_Cmd_Err for one cycle and leave o_LEDs unchanged.
REQ-025 o_Status_Req and o_Cmd_Err SHALL never be high in the same cycle.
REQ-026 An i_Rx_DV arriving during S_EXEC SHALL be dropped with no other effect.
REQ-027 Setting an LED that is already set, or clearing one already clear, SHALL be legal and raise no error.

Reset
REQ-028 On assertion of i_Rst_n low, the block SHALL immediately (asynchronously) clear o_LEDs to 8'h00, o_Status_Req, o_Cmd_Err and o_Busy to 0, and len to 0, and enter S_COLLECT.
REQ-029 Buffer contents need not be cleared at reset; len == 0 makes them invalid.
REQ-030 A reset asserted mid-command SHALL discard the partial line; the first 0x0A after reset release with no preceding bytes SHALL count as an empty line.

Verification
REQ-031 Scenario: bytes 'O','N','1',0x0A -> o_LEDs = 8'h01 exactly 2 cycles after the 0x0A strobe, with no pulses.
REQ-032 Scenario: "ON1\n", "ON2\n", "OF1\n" -> o_LEDs = 8'h01, then 8'h03, then 8'h02.
REQ-033 Scenario: "STATUS\r\n" -> o_Status_Req high for exactly 1 cycle, o_LEDs unchanged, o_Cmd_Err stays 0.
REQ-034 Scenario: "ON9\n", then the 10-character line "ABCDEFGHIJ\n", then a bare "\n" -> two o_Cmd_Err pulses, the bare "\n" gives no pulse, o_LEDs unchanged throughout.
REQ-035 Scenario: "ALLON\n" then "ALLOF\n" -> o_LEDs = 8'hFF, then 8'h00.
REQ-036 Scenario: "ON" then reset pulse then "3\n" -> o_Cmd_Err pulse ("3" alone is invalid), o_LEDs = 8'h00.
